// File: rtl/regfile_pkg.sv
// Shared helpers for the register file: width derivation and byte-enable merging.
package regfile_pkg;

    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(n)) r = i + 1;
        end
        return r;
    endfunction

    function automatic int unsigned calc_aw(input int unsigned depth);
        return clog2(depth);
    endfunction

    function automatic int unsigned calc_bw(input int unsigned width);
        int unsigned b;
        b = clog2(width / 8);
        return (b < 1) ? 1 : b;
    endfunction

    // Value a register holds after a write: new bytes where be is set, old bytes elsewhere.
    function automatic logic [63:0] byte_merge(input logic [63:0] old_v,
                                               input logic [63:0] new_v,
                                               input logic [7:0]  be);
        logic [63:0] r;
        r = old_v;
        for (int k = 0; k < 8; k++) begin
            if (be[k]) r[k*8 +: 8] = new_v[k*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_scan.sv
// Byte index selection for the LED display: manual select or timed auto-scan.
module byte_scan
    import regfile_pkg::*;
#(
    parameter int unsigned NB       = 4,
    parameter int unsigned BW       = 2,
    parameter int unsigned SCAN_DIV = 4,
    localparam int unsigned CW = (clog2(SCAN_DIV) < 1) ? 1 : clog2(SCAN_DIV)
) (
    input  logic          CLK,
    input  logic          Reset,
    input  logic          Scan_En,
    input  logic [BW-1:0] Byte_Sel,
    output logic [BW-1:0] Byte_Idx,
    output logic [BW-1:0] Byte_Idx_next
);

    localparam logic [CW-1:0] TERM = CW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] LAST = BW'(NB - 1);

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_next;
    logic [BW-1:0] r_idx;
    logic [BW-1:0] w_idx_next;
    logic [BW-1:0] w_sel;

    assign w_sel = BW'(32'(Byte_Sel) % NB);

    always_comb begin
        w_cnt_next = '0;
        w_idx_next = w_sel;
        if (Scan_En) begin
            if (r_cnt == TERM) begin
                w_cnt_next = '0;
                w_idx_next = (r_idx == LAST) ? '0 : r_idx + 1'b1;
            end else begin
                w_cnt_next = r_cnt + 1'b1;
                w_idx_next = r_idx;
            end
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else begin
            r_cnt <= w_cnt_next;
            r_idx <= w_idx_next;
        end
    end

    assign Byte_Idx      = r_idx;
    assign Byte_Idx_next = w_idx_next;

endmodule

// File: rtl/regfile_scan.sv
// Register file with byte-enabled writes, write-to-read bypass and a registered LED byte display.
module regfile_scan
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_R0  = 1,
    parameter int unsigned SCAN_DIV = 50_000_000,
    localparam int unsigned AW = calc_aw(DEPTH),
    localparam int unsigned BW = calc_bw(WIDTH),
    localparam int unsigned NB = WIDTH / 8
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [AW-1:0]    W_Addr,
    input  logic [WIDTH-1:0] W_Data,
    input  logic [NB-1:0]    W_BE,
    input  logic             Write_Reg,
    input  logic [AW-1:0]    R_Addr_A,
    input  logic [AW-1:0]    R_Addr_B,
    output logic [WIDTH-1:0] R_Data_A,
    output logic [WIDTH-1:0] R_Data_B,
    input  logic             A_B,
    input  logic             Scan_En,
    input  logic [BW-1:0]    Byte_Sel,
    output logic [BW-1:0]    Byte_Idx,
    output logic [7:0]       LED
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [7:0]       r_led;

    logic             w_wr_en;
    logic [63:0]      w_merged_full;
    logic [WIDTH-1:0] w_merged;
    logic             w_unused_merge;
    logic [WIDTH-1:0] w_rd_a;
    logic [WIDTH-1:0] w_rd_b;
    logic [WIDTH-1:0] w_disp;
    logic [7:0]       w_led_next;
    logic [BW-1:0]    w_idx_next;

    // A write to R0 is dropped entirely when R0 is hardwired, including its bypass.
    assign w_wr_en = Write_Reg && (|W_BE) && !((ZERO_R0 != 0) && (W_Addr == '0));

    assign w_merged_full  = byte_merge(64'(r_mem[W_Addr]), 64'(W_Data), 8'(W_BE));
    assign w_merged       = w_merged_full[WIDTH-1:0];
    assign w_unused_merge = ^w_merged_full;

    always_comb begin
        w_rd_a = r_mem[R_Addr_A];
        if ((ZERO_R0 != 0) && (R_Addr_A == '0)) w_rd_a = '0;
        if (w_wr_en && (R_Addr_A == W_Addr)) w_rd_a = w_merged;
        w_rd_b = r_mem[R_Addr_B];
        if ((ZERO_R0 != 0) && (R_Addr_B == '0)) w_rd_b = '0;
        if (w_wr_en && (R_Addr_B == W_Addr)) w_rd_b = w_merged;
    end

    assign R_Data_A = w_rd_a;
    assign R_Data_B = w_rd_b;

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_wr_en) begin
            r_mem[W_Addr] <= w_merged;
        end
    end

    byte_scan #(
        .NB       (NB),
        .BW       (BW),
        .SCAN_DIV (SCAN_DIV)
    ) u_byte_scan (
        .CLK           (CLK),
        .Reset         (Reset),
        .Scan_En       (Scan_En),
        .Byte_Sel      (Byte_Sel),
        .Byte_Idx      (Byte_Idx),
        .Byte_Idx_next (w_idx_next)
    );

    // Uses the post-edge byte index so LED and Byte_Idx always agree.
    always_comb begin
        w_disp     = A_B ? w_rd_b : w_rd_a;
        w_led_next = '0;
        for (int k = 0; k < NB; k++) begin
            if (w_idx_next == BW'(k)) w_led_next = w_disp[k*8 +: 8];
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) r_led <= '0;
        else       r_led <= w_led_next;
    end

    assign LED = r_led;

endmodule

// File: doc/regfile_scan.md
Name: regfile_scan

Overview:
- Parametrised register file: two combinational read ports (A, B), one synchronous write port with per-byte enables, optional hardwired-zero R0.
- Write-to-read bypass on both read ports.
- Registered 8-bit display path selects one byte of port A or B for the board LEDs, either manually or by auto-scanning the bytes.
- Successor to the fixed 32x32 register file/LED block in the lab top level.

Parameters:
- WIDTH, 32, register width in bits; multiple of 8, range 8..64.
- DEPTH, 32, number of registers; power of two, at least 2.
- ZERO_R0, 1, when 1 register 0 reads as zero and ignores writes.
- SCAN_DIV, 50_000_000, CLK cycles per byte step in scan mode; at least 1.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- W_Addr  in  AW  write address; AW = clog2(DEPTH).
- W_Data  in  WIDTH  write data.
- W_BE  in  WIDTH/8  byte write enables.
- Write_Reg  in  1  write strobe.
- R_Addr_A  in  AW  read address, port A.
- R_Addr_B  in  AW  read address, port B.
- R_Data_A  out  WIDTH  read data, port A.
- R_Data_B  out  WIDTH  read data, port B.
- A_B  in  1  display source: 0 = port A, 1 = port B.
- Scan_En  in  1  1 = auto-scan bytes, 0 = manual.
- Byte_Sel  in  BW  manual byte index; BW = max(1, clog2(WIDTH/8)).
- Byte_Idx  out  BW  byte index currently displayed.
- LED  out  8  displayed byte.

Behaviour:
- Reset (asynchronous, active-high):
  - all registers = 0, LED = 0, Byte_Idx = 0, scan counter = 0.
  - Reset asserted mid-write: the write is lost.
  - Reset deasserted: first write lands on the next CLK rising edge.
- Write:
  - On a CLK edge with Write_Reg=1, for each byte k with W_BE[k]=1, reg[W_Addr] byte k <= W_Data byte k.
  - Bytes with W_BE[k]=0 are unchanged.
  - W_BE all zero = no write.
  - ZERO_R0=1 and W_Addr=0: write is dropped.
- Read:
  - Combinational: R_Data_X = reg[R_Addr_X].
  - ZERO_R0=1 and R_Addr_X=0: R_Data_X = 0.
- Bypass:
  - Condition: Write_Reg=1 and R_Addr_X == W_Addr, and the write is not dropped by ZERO_R0.
  - R_Data_X = merge of the old register and W_Data under W_BE, i.e. the value the register will hold after the edge.
  - Both ports may bypass the same write simultaneously.
- Byte index:
  - Scan_En=0: Byte_Idx <= Byte_Sel every CLK.
  - Byte_Sel >= WIDTH/8 wraps modulo WIDTH/8; this only matters for non-power-of-two byte counts.
  - Scan_En=1: scan counter counts 0..SCAN_DIV-1. On the terminal count, counter -> 0 and Byte_Idx -> (Byte_Idx+1) mod WIDTH/8, wrapping from last byte to 0.
  - Scan_En deasserted: counter cleared to 0.
  - Scan_En reasserted: scan resumes from the current Byte_Idx.
- Display:
  - LED <= byte Byte_Idx_next of (A_B ? R_Data_B : R_Data_A), registered.
  - Byte_Idx_next is the value Byte_Idx takes at the same edge.
  - Latency: one CLK from a change of address, A_B, Byte_Sel or a write to the displayed register.
  - Display includes bypass data, so a write to the displayed register appears on LED at the write edge itself.
- WIDTH=8: BW=1, Byte_Idx stays 0, scan has no visible effect.

Decomposition:
- Shared package regfile_pkg:
  - clog2 function.
  - AW/BW derivation.
  - byte-merge function (old, new, BE) used by write and bypass.
- One sub-module, byte_scan:
  - scan counter and Byte_Idx register.
  - inputs: CLK, Reset, Scan_En, Byte_Sel.
  - outputs: Byte_Idx, Byte_Idx_next.
- Storage array, bypass and LED register stay in regfile_scan.

Test Plan:
All tests use WIDTH=32, DEPTH=32, ZERO_R0=1 unless stated.
- Reset and basic write/read:
  - Reset=1 at t=0, release at 20 ns.
  - Write R1=0x00000DB0, BE=4'b1111.
  - Then R_Addr_A=1, A_B=0, Byte_Sel=0 -> LED=0xB0. Byte_Sel=1 -> LED=0x0D one CLK later.
  - All other registers read 0.
- Byte enables:
  - R3=0xFFFFFFFF, then write 0x12345678 with BE=4'b0101 -> R3 reads 0xFF34FF78.
  - Port B on R3, A_B=1, Byte_Sel=2 -> LED=0x34.
- R0 and bypass:
  - Write R0=0xDEADBEEF -> R_Data_A(0)=0.
  - Write R5=0xAABBCCDD with R_Addr_A=R_Addr_B=5 -> both ports show 0xAABBCCDD combinationally during the write cycle.
  - LED=0xDD at that edge with Byte_Sel=0.
- Auto-scan with SCAN_DIV=4:
  - R2=0x44332211, Scan_En=1.
  - LED steps 0x11, 0x22, 0x33, 0x44, 0x11, advancing every 4 CLKs.
  - Byte_Idx wraps 3 -> 0.
- Reset mid-operation:
  - Assert Reset asynchronously between edges during scan with Byte_Idx=2 and a pending write to R7.
  - LED=0 and Byte_Idx=0 immediately, without waiting for a clock edge.
  - R7 reads 0 after release.
- ZERO_R0=0, DEPTH=4, WIDTH=16:
  - Write R0=0xBEEF -> R0 reads 0xBEEF.
  - Byte_Sel=1 -> LED=0xBE.
